// File: rtl/prog_counter.sv
// Run-controlled event counter with prescaler: programmable terminal value,
// up/down, wrap/saturate/one-shot, registered tick/tc strobes.
module prog_counter #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_count,
  input  logic [PRE_W-1:0] delay,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | stopped, count held
  // RUN   | prescaler running, steps taken
  // DONE  | one-shot reached its terminal value
  // ILL   | unreachable encoding, recovers to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_ILL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_cnt;
  logic             step_term;
  logic             step_end;

  // Value a step would produce; max_count may have been lowered below count.
  always_comb begin
    step_cnt  = count_q;
    step_term = 1'b0;
    step_end  = 1'b0;
    if (!dir) begin
      if (count_q < max_count) begin
        step_cnt = count_q + WIDTH'(1);
      end else begin
        step_term = 1'b1;
        case (mode)
          2'b01:   step_cnt = max_count;
          2'b10: begin
            step_cnt = max_count;
            step_end = 1'b1;
          end
          default: step_cnt = '0;
        endcase
      end
    end else begin
      if (count_q > max_count) begin
        step_cnt = max_count;
      end else if (count_q != '0) begin
        step_cnt = count_q - WIDTH'(1);
      end else begin
        step_term = 1'b1;
        case (mode)
          2'b01:   step_cnt = '0;
          2'b10: begin
            step_cnt = '0;
            step_end = 1'b1;
          end
          default: step_cnt = max_count;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
      pre_d   = '0;
      state_d = S_IDLE;
    end else if (load) begin
      count_d = (load_value > max_count) ? max_count : load_value;
      pre_d   = '0;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_IDLE;
    end else if (start && state_q != S_RUN) begin
      if (state_q == S_DONE) count_d = dir ? max_count : '0;
      pre_d   = '0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      // >= rather than == so a mid-run drop of delay cannot stall the prescaler
      if (pre_q >= delay) begin
        pre_d   = '0;
        count_d = step_cnt;
        tick_d  = 1'b1;
        tc_d    = step_term;
        if (step_end) state_d = S_DONE;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
    if (state_q == S_ILL) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios with literal expectations plus
// randomized control traffic checked every cycle against a behavioural model.
module tb_prog_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [15:0] load_value = '0;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] max_count = '0;
  logic [31:0] delay = '0;
  logic [15:0] count;
  logic        tick, tc, busy, done;

  int total = 0;
  int bad   = 0;

  prog_counter #(.WIDTH(16), .PRE_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .dir(dir), .mode(mode),
    .max_count(max_count), .delay(delay), .count(count), .tick(tick),
    .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = stopped, 1 = running, 2 = finished one-shot.
  typedef struct {
    int          cnt;
    longint      wait_cycles;
    int          phase;
    bit          tick;
    bit          tc;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur);
    model_t n;
    int top;
    n = cur;
    n.tick = 0;
    n.tc = 0;
    top = int'(max_count);
    if (clear) begin
      n.cnt = 0; n.wait_cycles = 0; n.phase = 0;
    end else if (load) begin
      n.cnt = (int'(load_value) < top) ? int'(load_value) : top;
      n.wait_cycles = 0;
      if (cur.phase == 2) n.phase = 0;
    end else if (stop) begin
      if (cur.phase == 1) n.phase = 0;
    end else if (start && cur.phase != 1) begin
      if (cur.phase == 2) n.cnt = dir ? top : 0;
      n.wait_cycles = 0;
      n.phase = 1;
    end else if (cur.phase == 1) begin
      if (cur.wait_cycles >= longint'(delay)) begin
        n.wait_cycles = 0;
        n.tick = 1;
        if (dir == 1'b0) begin
          if (cur.cnt < top) n.cnt = cur.cnt + 1;
          else begin
            n.tc = 1;
            n.cnt = (mode == 2'b00 || mode == 2'b11) ? 0 : top;
            if (mode == 2'b10) n.phase = 2;
          end
        end else begin
          if (cur.cnt > top) n.cnt = top;
          else if (cur.cnt > 0) n.cnt = cur.cnt - 1;
          else begin
            n.tc = 1;
            n.cnt = (mode == 2'b00 || mode == 2'b11) ? top : 0;
            if (mode == 2'b10) n.phase = 2;
          end
        end
      end else begin
        n.wait_cycles = cur.wait_cycles + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{cnt: 0, wait_cycles: 0, phase: 0, tick: 0, tc: 0};
    else      m <= model_next(m);
  end

  always @(negedge clk) begin
    check("model_count", 64'(count), 64'(m.cnt));
    check("model_tick",  64'(tick),  64'(m.tick));
    check("model_tc",    64'(tc),    64'(m.tc));
    check("model_busy",  64'(busy),  64'(m.phase == 1));
    check("model_done",  64'(done),  64'(m.phase == 2));
  end

  task automatic pulse_start(); start = 1; @(negedge clk); start = 0; endtask
  task automatic pulse_stop();  stop  = 1; @(negedge clk); stop  = 0; endtask
  task automatic pulse_clear(); clear = 1; @(negedge clk); clear = 0; endtask
  task automatic pulse_load();  load  = 1; @(negedge clk); load  = 0; endtask

  initial begin
    int exp_up [6];
    int exp_dn [4];
    bit hit;
    exp_up = '{1, 2, 3, 4, 5, 0};
    exp_dn = '{1, 0, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_count", 64'(count), 0);
    check("rst_busy",  64'(busy),  0);
    rst = 1;
    @(negedge clk);

    // basic wrap up count
    delay = 0; max_count = 5; mode = 2'b00; dir = 0;
    pulse_start();
    check("up_busy", 64'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("up_count", 64'(count), 64'(exp_up[i]));
      check("up_tc",    64'(tc),    64'(i == 5));
    end
    pulse_stop();

    // prescaler
    pulse_clear();
    delay = 3; max_count = 16'hFFFF;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("pre_tick", 64'(tick), 64'((i % 4) == 3));
    end
    check("pre_count", 64'(count), 3);
    pulse_stop();
    check("stop_busy",  64'(busy),  0);
    check("stop_count", 64'(count), 3);
    @(negedge clk);
    check("stop_hold", 64'(count), 3);

    // saturate down
    load_value = 2;
    pulse_load();
    check("load_count", 64'(count), 2);
    dir = 1; mode = 2'b01; delay = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sat_count", 64'(count), 64'(exp_dn[i]));
      check("sat_tc",    64'(tc),    64'(i >= 2));
      check("sat_tick",  64'(tick),  1);
    end
    pulse_stop();

    // one-shot up
    pulse_clear();
    max_count = 3; mode = 2'b10; dir = 0;
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("os_count", 64'(count), 64'(i));
    end
    @(negedge clk);
    check("os_end_count", 64'(count), 3);
    check("os_done",      64'(done),  1);
    check("os_busy",      64'(busy),  0);
    check("os_tc",        64'(tc),    1);
    pulse_start();
    check("os_restart_count", 64'(count), 0);
    check("os_restart_busy",  64'(busy),  1);
    pulse_stop();

    // priority and bounds
    clear = 1; load = 1; start = 1; load_value = 7;
    @(negedge clk);
    clear = 0; load = 0; start = 0;
    check("prio_count", 64'(count), 0);
    check("prio_busy",  64'(busy),  0);
    load_value = 9; max_count = 4;
    pulse_load();
    check("clamp_count", 64'(count), 4);
    mode = 2'b00; dir = 0; delay = 0; max_count = 2;
    pulse_start();
    @(negedge clk);
    check("lower_max_count", 64'(count), 0);
    check("lower_max_tc",    64'(tc),    1);
    pulse_stop();

    // async reset mid-run
    pulse_clear();
    delay = 1; max_count = 16'hFFFF;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (count == 16'd7) hit = 1;
    end
    check("arst_reach7", 64'(hit), 1);
    #2 rst = 0;
    #1;
    check("arst_count", 64'(count), 0);
    check("arst_busy",  64'(busy),  0);
    check("arst_tick",  64'(tick),  0);
    check("arst_tc",    64'(tc),    0);
    check("arst_done",  64'(done),  0);
    @(negedge clk);
    rst = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 4);
      stop  = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 5) max_count = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 5) delay = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 5) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
      load_value = 16'($urandom_range(0, 20));
    end
    @(negedge clk);
    clear = 0; load = 0; stop = 0; start = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
